// File: rtl/cmd_pkt_rtn_fifo.sv
// Store-and-forward packet FIFO: whole packets are committed before they are
// offered downstream with a request/ack handshake and a fixed idle gap after each.
module cmd_pkt_rtn_fifo #(
  parameter int DW      = 8,
  parameter int AW      = 11,
  parameter int GAP     = 8,
  parameter int MAX_PKT = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] rx_din,
  input  logic          rx_din_en,
  input  logic          tx_ack,
  output logic [DW-1:0] tx_dout,
  output logic          tx_dout_en,
  output logic [AW:0]   pkt_cnt,
  output logic [15:0]   drop_cnt
);

  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] MAX_PKT_W = AW'(MAX_PKT);
  localparam logic [AW-1:0] MAX_LAST  = AW'(MAX_PKT - 1);
  localparam logic [7:0]    GAP_LAST  = 8'(GAP - 1);

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_DROP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_DATA, RD_GAP} rd_state_t;

  wr_state_t     wr_state;
  rd_state_t     rd_state;
  logic [DW:0]   mem [DEPTH];
  logic [DW:0]   ram_q;
  logic [DW-1:0] rx_din_r;
  logic          rx_din_en_r;
  logic [AW-1:0] wr_ptr, commit_ptr, rd_ptr, rd_addr, wr_cnt, free_space;
  logic [7:0]    gap_cnt;
  logic          rx_last, rx_rise, overflow, wr_en, commit, drop_evt, pkt_take;

  assign rx_last    = rx_din_en_r & ~rx_din_en;
  assign rx_rise    = rx_din_en & ~rx_din_en_r;
  assign free_space = {AW{1'b1}} - (wr_ptr - rd_ptr);
  assign overflow   = (wr_state == WR_DATA) && rx_din_en_r && rx_din_en && (wr_cnt == MAX_LAST);
  assign wr_en      = (wr_state == WR_DATA) && rx_din_en_r && !overflow;
  assign commit     = wr_en && rx_last;
  assign drop_evt   = overflow || ((wr_state == WR_IDLE) && rx_rise && (free_space < MAX_PKT_W));
  assign pkt_take   = (rd_state == RD_REQ) && tx_ack;
  assign rd_addr    = (rd_state == RD_DATA) ? rd_ptr + AW'(1) : rd_ptr;

  // Enable register resets high so a packet already in flight at reset release
  // is seen as mid-packet and silently discarded rather than counted as a drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_din_r    <= '0;
      rx_din_en_r <= 1'b1;
    end else begin
      rx_din_r    <= rx_din;
      rx_din_en_r <= rx_din_en;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {rx_last, rx_din_r};
    ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state   <= WR_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      wr_cnt     <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          wr_cnt <= '0;
          if (rx_rise)
            wr_state <= (free_space >= MAX_PKT_W) ? WR_DATA : WR_DROP;
          else if (rx_din_en && rx_din_en_r)
            wr_state <= WR_DROP;
        end
        WR_DATA: begin
          if (overflow) begin
            wr_ptr   <= commit_ptr;
            wr_state <= WR_DROP;
          end else if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            wr_cnt <= wr_cnt + AW'(1);
            if (rx_last) begin
              commit_ptr <= wr_ptr + AW'(1);
              wr_state   <= WR_IDLE;
            end
          end
        end
        WR_DROP: if (!rx_din_en) wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Outputs are loaded for the state being entered, so the RAM read issued
  // while waiting for ack is already valid on the first data cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state   <= RD_IDLE;
      rd_ptr     <= '0;
      gap_cnt    <= '0;
      tx_dout    <= '0;
      tx_dout_en <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          tx_dout <= '0;
          if (pkt_cnt != '0) begin
            rd_state   <= RD_REQ;
            tx_dout_en <= 1'b1;
          end else begin
            tx_dout_en <= 1'b0;
          end
        end
        RD_REQ: begin
          tx_dout    <= '0;
          tx_dout_en <= 1'b1;
          if (tx_ack) rd_state <= RD_DATA;
        end
        RD_DATA: begin
          tx_dout    <= ram_q[DW-1:0];
          tx_dout_en <= 1'b1;
          rd_ptr     <= rd_ptr + AW'(1);
          if (ram_q[DW]) begin
            rd_state <= RD_GAP;
            gap_cnt  <= '0;
          end
        end
        RD_GAP: begin
          tx_dout    <= '0;
          tx_dout_en <= 1'b0;
          if (gap_cnt == GAP_LAST) rd_state <= RD_IDLE;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (commit && !pkt_take) pkt_cnt <= pkt_cnt + (AW+1)'(1);
      else if (!commit && pkt_take) pkt_cnt <= pkt_cnt - (AW+1)'(1);
      if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cmd_pkt_rtn_fifo.sv
// Directed bench for cmd_pkt_rtn_fifo: small FIFO (AW=5, MAX_PKT=16, GAP=8)
// so overflow and full-buffer drops are reachable in a few hundred cycles.
module tb_cmd_pkt_rtn_fifo;

  localparam int DW = 8, AW = 5, GAP = 8, MAX_PKT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rx_din;
  logic          rx_din_en;
  logic          tx_ack;
  logic [DW-1:0] tx_dout;
  logic          tx_dout_en;
  logic [AW:0]   pkt_cnt;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int errors = 0;
  int n;
  int bad;

  cmd_pkt_rtn_fifo #(.DW(DW), .AW(AW), .GAP(GAP), .MAX_PKT(MAX_PKT)) dut (
    .clk(clk), .rst(rst), .rx_din(rx_din), .rx_din_en(rx_din_en), .tx_ack(tx_ack),
    .tx_dout(tx_dout), .tx_dout_en(tx_dout_en), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One packet of len words, base + i*inc, followed by one idle cycle.
  task automatic applyStimulus(input int len, input logic [7:0] base, input logic [7:0] inc);
    logic [7:0] w;
    w = base;
    for (int i = 0; i < len; i++) begin
      rx_din    = w;
      rx_din_en = 1'b1;
      step();
      w = w + inc;
    end
    rx_din_en = 1'b0;
    rx_din    = '0;
    step();
  endtask

  task automatic waitReq(input string tag);
    int k;
    k = 0;
    while (tx_dout_en !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    checkOutput({tag, " req en"}, 32'(tx_dout_en), 32'd1);
    checkOutput({tag, " req dout"}, 32'(tx_dout), 32'd0);
  endtask

  // Called in the cycle after ack was sampled; ends one cycle past the last word.
  task automatic recvWords(input string tag, input int len, input logic [7:0] base, input logic [7:0] inc);
    logic [7:0] w;
    w = base;
    checkOutput({tag, " latency en"}, 32'(tx_dout_en), 32'd1);
    checkOutput({tag, " latency dout"}, 32'(tx_dout), 32'd0);
    for (int i = 0; i < len; i++) begin
      step();
      checkOutput($sformatf("%s word%0d", tag, i), {23'd0, tx_dout_en, tx_dout}, {23'd0, 1'b1, w});
      w = w + inc;
    end
    step();
    checkOutput({tag, " end en"}, 32'(tx_dout_en), 32'd0);
  endtask

  task automatic takePacket(input string tag, input int len, input logic [7:0] base, input logic [7:0] inc);
    waitReq(tag);
    step();
    recvWords(tag, len, base, inc);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; rx_din = '0; rx_din_en = 1'b0; tx_ack = 1'b0;
    repeat (3) step();
    checkOutput("reset tx_dout_en", 32'(tx_dout_en), 32'd0);
    checkOutput("reset tx_dout", 32'(tx_dout), 32'd0);
    checkOutput("reset pkt_cnt", 32'(pkt_cnt), 32'd0);
    checkOutput("reset drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    repeat (2) step();

    // 4-word packet with ack held high
    tx_ack = 1'b1;
    applyStimulus(4, 8'h11, 8'h11);
    checkOutput("t1 pkt_cnt stored", 32'(pkt_cnt), 32'd1);
    checkOutput("t1 idle en", 32'(tx_dout_en), 32'd0);
    waitReq("t1");
    checkOutput("t1 pkt_cnt in req", 32'(pkt_cnt), 32'd1);
    step();
    recvWords("t1", 4, 8'h11, 8'h11);
    checkOutput("t1 pkt_cnt after", 32'(pkt_cnt), 32'd0);
    n = 0;
    repeat (GAP) begin
      if (tx_dout_en === 1'b0 && tx_dout === '0) n++;
      step();
    end
    checkOutput("t1 gap low cycles", 32'(n), 32'(GAP));

    // Request held without ack for 100 cycles
    tx_ack = 1'b0;
    applyStimulus(2, 8'hA0, 8'h01);
    waitReq("t2");
    bad = 0;
    repeat (100) begin
      step();
      if (!(tx_dout_en === 1'b1 && tx_dout === '0 && pkt_cnt === 6'd1)) bad++;
    end
    checkOutput("t2 stall cycles bad", 32'(bad), 32'd0);
    tx_ack = 1'b1;
    step();
    checkOutput("t2 pkt_cnt after ack", 32'(pkt_cnt), 32'd0);
    recvWords("t2", 2, 8'hA0, 8'h01);

    // Back-to-back packets, single-word packet and exact gap between them
    tx_ack = 1'b0;
    applyStimulus(3, 8'h30, 8'h01);
    applyStimulus(1, 8'h5A, 8'h00);
    checkOutput("t3 pkt_cnt two", 32'(pkt_cnt), 32'd2);
    tx_ack = 1'b1;
    takePacket("t3a", 3, 8'h30, 8'h01);
    n = 0;
    while (tx_dout_en === 1'b0 && n < 50) begin
      n++;
      step();
    end
    checkOutput("t3 gap between packets", 32'(n), 32'(GAP));
    checkOutput("t3b req dout", 32'(tx_dout), 32'd0);
    step();
    recvWords("t3b", 1, 8'h5A, 8'h00);
    checkOutput("t3 pkt_cnt after", 32'(pkt_cnt), 32'd0);

    // Commit and transmit start on the same edge
    tx_ack = 1'b0;
    applyStimulus(2, 8'h60, 8'h01);
    waitReq("t4a");
    checkOutput("t4 pkt_cnt before", 32'(pkt_cnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      rx_din    = 8'h70 + 8'(i);
      rx_din_en = 1'b1;
      step();
    end
    rx_din_en = 1'b0;
    rx_din    = '0;
    tx_ack    = 1'b1;
    step();
    checkOutput("t4 pkt_cnt simultaneous", 32'(pkt_cnt), 32'd1);
    recvWords("t4a", 2, 8'h60, 8'h01);
    takePacket("t4b", 3, 8'h70, 8'h01);
    checkOutput("t4 pkt_cnt after", 32'(pkt_cnt), 32'd0);

    // Oversized packet is rewound and dropped, the next one survives
    tx_ack = 1'b0;
    applyStimulus(20, 8'h80, 8'h01);
    checkOutput("t5 drop_cnt", 32'(drop_cnt), 32'd1);
    checkOutput("t5 pkt_cnt after drop", 32'(pkt_cnt), 32'd0);
    applyStimulus(3, 8'hC0, 8'h01);
    checkOutput("t5 pkt_cnt stored", 32'(pkt_cnt), 32'd1);
    tx_ack = 1'b1;
    takePacket("t5", 3, 8'hC0, 8'h01);

    // Buffer full: one 16-word packet fits, four more are dropped
    tx_ack = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(16, 8'(k * 16), 8'h01);
    checkOutput("t6 drop_cnt", 32'(drop_cnt), 32'd5);
    checkOutput("t6 pkt_cnt", 32'(pkt_cnt), 32'd1);
    tx_ack = 1'b1;
    takePacket("t6", 16, 8'h00, 8'h01);
    checkOutput("t6 pkt_cnt after", 32'(pkt_cnt), 32'd0);

    // Reset in the middle of a transmission with another packet queued
    tx_ack = 1'b0;
    applyStimulus(8, 8'hD0, 8'h01);
    applyStimulus(2, 8'hE0, 8'h01);
    checkOutput("t7 pkt_cnt two", 32'(pkt_cnt), 32'd2);
    tx_ack = 1'b1;
    waitReq("t7");
    step();
    step();
    step();
    checkOutput("t7 word1 before reset", 32'(tx_dout), 32'hD1);
    #2 rst = 1'b0;
    #1;
    checkOutput("t7 reset en", 32'(tx_dout_en), 32'd0);
    checkOutput("t7 reset dout", 32'(tx_dout), 32'd0);
    checkOutput("t7 reset pkt_cnt", 32'(pkt_cnt), 32'd0);
    rx_din    = 8'hEE;
    rx_din_en = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rx_din_en = 1'b0;
    rx_din    = '0;
    bad = 0;
    repeat (30) begin
      step();
      if (tx_dout_en !== 1'b0) bad++;
    end
    checkOutput("t7 no tx after reset", 32'(bad), 32'd0);
    checkOutput("t7 pkt_cnt after release", 32'(pkt_cnt), 32'd0);
    checkOutput("t7 drop_cnt after release", 32'(drop_cnt), 32'd0);
    applyStimulus(5, 8'h40, 8'h03);
    checkOutput("t7 pkt_cnt new", 32'(pkt_cnt), 32'd1);
    takePacket("t7", 5, 8'h40, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
